stream_split_fifo: RTL and testbench
====================================

Name: stream_split_fifo

Overview:
- Producer-side counterpart of the two-stream join/sum queue.
- Accepts one upstream word of 2*D_WIDTH bits per push, splits it into an upper half (lane A) and a lower half (lane B), and buffers each half in its own FIFO.
- Each lane is drained independently by its own pop, so two downstream consumers can run at different rates from a single producer.

Parameters:
- D_WIDTH, 6, width of each lane's data word.
- DEPTH, 4, entries per lane FIFO; must be at least 2.

Ports:
- clk  input  1  single clock; all logic sampled on rising edge.
- rst  input  1  asynchronous, active-low reset; deasserted synchronously to clk externally.
- up_data  input  2*D_WIDTH  upstream word; [2*D_WIDTH-1:D_WIDTH] goes to lane A, [D_WIDTH-1:0] goes to lane B.
- push  input  1  write request for up_data.
- full  output  1  high when either lane FIFO holds DEPTH entries.
- down_data_a  output  D_WIDTH  head of lane A FIFO.
- down_data_b  output  D_WIDTH  head of lane B FIFO.
- pop_a  input  1  remove lane A head.
- pop_b  input  1  remove lane B head.
- empty_a  output  1  lane A holds zero entries.
- empty_b  output  1  lane B holds zero entries.
- count_a  output  $clog2(DEPTH+1)  lane A occupancy.
- count_b  output  $clog2(DEPTH+1)  lane B occupancy.
- overflow  output  1  sticky flag: a push was dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - Both FIFOs are emptied, with pointers at 0.
  - count_a=count_b=0, empty_a=empty_b=1, full=0, overflow=0, down_data_a=down_data_b=0.
- Push acceptance:
  - A push is accepted at an edge iff push=1 and pre-edge count_a<DEPTH and count_b<DEPTH.
  - When accepted, both halves are written in the same cycle.
  - A lane never receives a half without the other lane receiving its half.
- Dropped push:
  - A push while full=1 is dropped entirely; neither lane is written.
  - overflow is set to 1 and stays set until reset.
  - Full is judged on pre-edge counts. A simultaneous pop does not make room for a push in that same cycle.
- Pop:
  - pop_x with empty_x=1 is ignored; no underflow, no flag.
  - pop_x with empty_x=0 removes the head at the edge.
- Simultaneous accepted push and valid pop on the same lane: count_x is unchanged and both pointers advance.
- Occupancy:
  - The lanes diverge only through pops; count_a and count_b are independent.
  - full = (count_a==DEPTH) | (count_b==DEPTH).
  - empty_x = (count_x==0).
  - All flags and counts are registered and reflect post-edge state.
- Head data (show-ahead, registered):
  - down_data_x equals the oldest entry of lane x whenever empty_x=0.
  - Latency: after a push into an empty lane, data and empty_x=0 are visible one cycle after the push edge.
  - When lane x becomes empty, down_data_x is driven to 0.
  - Contents are only valid while empty_x=0.
- Wrap-around: read and write pointers are mod DEPTH. DEPTH need not be a power of 2; the pointer wraps at DEPTH-1 to 0.
- Storage: two arrays of DEPTH x D_WIDTH. Storage is not required to be reset, but outputs must obey the rules above.
- Reset mid-operation: all state is discarded immediately; outputs take their reset values asynchronously. The first push after rst returns high behaves as a push into an empty FIFO.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst=0 mid-stream with both lanes holding 3 entries.
  - Required response: immediately count_a=count_b=0, empty_a=empty_b=1, down_data_a=down_data_b=0, overflow=0.
- Split and latency:
  - Stimulus: from empty, push up_data=12'hA53 for one cycle.
  - Required response: next cycle down_data_a=6'h29, down_data_b=6'h13, count_a=count_b=1, empty_a=empty_b=0.
- Independent drain:
  - Stimulus: push 12'h041, 12'h082, 12'h0C3; then pop_a for 3 cycles with pop_b=0.
  - Required response:
    - down_data_a goes 1,2,3, then empty_a=1 with down_data_a=0.
    - count_b stays 3 and down_data_b stays 6'h01.
    - full=0 throughout.
- Full and overflow:
  - Stimulus: push 4 words, then drain lane B only, then push again.
  - Required response: full=1; the 5th push is dropped, lane B is not written, overflow=1 sticky, count_a=4, count_b=0.
- Boundary simultaneity:
  - Stimulus: with count_a=4, drive push=1 and pop_a=1 together.
  - Required response: push dropped, overflow=1, count_a=3.
  - Stimulus: with count_a=count_b=2, drive push and pop_a together.
  - Required response: count_a=2, count_b=3.
- Wrap-around with DEPTH=3:
  - Stimulus: run 10 push/pop cycles at steady occupancy 2.
  - Required response: data order preserved on both lanes across pointer wrap; pop on empty lane is ignored with no count change.

Source files
------------

// File: rtl/stream_split_fifo_if.sv
// Handshake and status bundle for stream_split_fifo.
// The producer/consumer side uses master; the FIFO uses slave.
interface stream_split_fifo_if #(
  parameter int unsigned D_WIDTH = 6,
  parameter int unsigned DEPTH   = 4
);
  logic [2*D_WIDTH-1:0]         up_data;
  logic                         push;
  logic                         full;
  logic [D_WIDTH-1:0]           down_data_a;
  logic [D_WIDTH-1:0]           down_data_b;
  logic                         pop_a;
  logic                         pop_b;
  logic                         empty_a;
  logic                         empty_b;
  logic [$clog2(DEPTH+1)-1:0]   count_a;
  logic [$clog2(DEPTH+1)-1:0]   count_b;
  logic                         overflow;

  modport master (
    output up_data, push, pop_a, pop_b,
    input  full, down_data_a, down_data_b, empty_a, empty_b, count_a, count_b, overflow
  );

  modport slave (
    input  up_data, push, pop_a, pop_b,
    output full, down_data_a, down_data_b, empty_a, empty_b, count_a, count_b, overflow
  );
endinterface

// File: rtl/stream_split_fifo.sv
// Splits each 2*D_WIDTH upstream word into two D_WIDTH lanes, each buffered in
// its own FIFO with a registered show-ahead head and an independent pop.
module stream_split_fifo #(
  parameter int unsigned D_WIDTH = 6,
  parameter int unsigned DEPTH   = 4
) (
  input logic              clk,
  input logic              rst,
  stream_split_fifo_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [1:0][D_WIDTH-1:0] lane_din;
  logic [1:0]              lane_pop;
  logic [1:0][CntW-1:0]    lane_count;
  logic [1:0][D_WIDTH-1:0] lane_head;
  logic                    full;
  logic                    push_ok;
  logic                    overflow_q;

  assign lane_din[0] = bus.up_data[2*D_WIDTH-1:D_WIDTH];
  assign lane_din[1] = bus.up_data[D_WIDTH-1:0];
  assign lane_pop[0] = bus.pop_a;
  assign lane_pop[1] = bus.pop_b;

  // Full is judged on pre-edge counts, so a same-cycle pop never admits a push.
  assign full    = (lane_count[0] == CntW'(DEPTH)) | (lane_count[1] == CntW'(DEPTH));
  assign push_ok = bus.push & ~full;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]    wptr_q, wptr_d;
    logic [PtrW-1:0]    rptr_q, rptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [D_WIDTH-1:0] head_q, head_d;
    logic               pop_ok;

    assign pop_ok = lane_pop[l] & (count_q != '0);

    always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      head_d  = head_q;
      if (push_ok) wptr_d = ptr_inc(wptr_q);
      if (pop_ok)  rptr_d = ptr_inc(rptr_q);
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (!push_ok && pop_ok) count_d = count_q - 1'b1;

      // The new head is either already in storage or is the word being written now.
      if (count_d == '0) begin
        head_d = '0;
      end else if (pop_ok) begin
        head_d = (count_q == CntW'(1)) ? lane_din[l] : mem[rptr_d];
      end else if (count_q == '0) begin
        head_d = lane_din[l];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
        head_q  <= '0;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
        head_q  <= head_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push_ok) mem[wptr_q] <= lane_din[l];
    end

    assign lane_count[l] = count_q;
    assign lane_head[l]  = head_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (bus.push && full) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.full        = full;
  assign bus.overflow    = overflow_q;
  assign bus.count_a     = lane_count[0];
  assign bus.count_b     = lane_count[1];
  assign bus.empty_a     = (lane_count[0] == '0);
  assign bus.empty_b     = (lane_count[1] == '0);
  assign bus.down_data_a = lane_head[0];
  assign bus.down_data_b = lane_head[1];

endmodule

// File: tb/tb_stream_split_fifo.sv
// Drives a DEPTH=4 and a DEPTH=3 instance with identical stimulus and checks
// both against queue-based lane models.
module tb_stream_split_fifo;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  stream_split_fifo_if #(.D_WIDTH(6), .DEPTH(4)) bus0 ();
  stream_split_fifo_if #(.D_WIDTH(6), .DEPTH(3)) bus1 ();

  stream_split_fifo #(.D_WIDTH(6), .DEPTH(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  stream_split_fifo #(.D_WIDTH(6), .DEPTH(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef logic [5:0] word_q_t [$];
  word_q_t mq [4];          // index = dut*2 + lane (lane 0 = A, 1 = B)
  bit      movf [2];
  int      mdepth [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    movf[0] = 1'b0;
    movf[1] = 1'b0;
  endtask

  task automatic model_edge(input bit p, input logic [11:0] d, input bit pa, input bit pb);
    for (int u = 0; u < 2; u++) begin
      bit accept;
      accept = p && (mq[2*u].size() < mdepth[u]) && (mq[2*u+1].size() < mdepth[u]);
      if (p && !accept) movf[u] = 1'b1;
      if (pa && mq[2*u].size() > 0)   void'(mq[2*u].pop_front());
      if (pb && mq[2*u+1].size() > 0) void'(mq[2*u+1].pop_front());
      if (accept) begin
        mq[2*u].push_back(d[11:6]);
        mq[2*u+1].push_back(d[5:0]);
      end
    end
  endtask

  task automatic check_dut(input int u, input logic [31:0] ca, input logic [31:0] cb,
                           input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] fu,
                           input logic [31:0] da, input logic [31:0] db, input logic [31:0] ov);
    int sa, sb;
    sa = mq[2*u].size();
    sb = mq[2*u+1].size();
    check($sformatf("d%0d_count_a", u), ca, 32'(sa));
    check($sformatf("d%0d_count_b", u), cb, 32'(sb));
    check($sformatf("d%0d_empty_a", u), ea, 32'(sa == 0));
    check($sformatf("d%0d_empty_b", u), eb, 32'(sb == 0));
    check($sformatf("d%0d_full", u), fu, 32'((sa == mdepth[u]) || (sb == mdepth[u])));
    check($sformatf("d%0d_head_a", u), da, (sa > 0) ? 32'(mq[2*u][0]) : 32'd0);
    check($sformatf("d%0d_head_b", u), db, (sb > 0) ? 32'(mq[2*u+1][0]) : 32'd0);
    check($sformatf("d%0d_overflow", u), ov, 32'(movf[u]));
  endtask

  task automatic check_all();
    check_dut(0, 32'(bus0.count_a), 32'(bus0.count_b), 32'(bus0.empty_a), 32'(bus0.empty_b),
              32'(bus0.full), 32'(bus0.down_data_a), 32'(bus0.down_data_b), 32'(bus0.overflow));
    check_dut(1, 32'(bus1.count_a), 32'(bus1.count_b), 32'(bus1.empty_a), 32'(bus1.empty_b),
              32'(bus1.full), 32'(bus1.down_data_a), 32'(bus1.down_data_b), 32'(bus1.overflow));
  endtask

  // Called at a negedge; applies one cycle of stimulus and checks after the edge.
  task automatic step(input bit p, input logic [11:0] d, input bit pa, input bit pb);
    bus0.push = p;  bus0.up_data = d;  bus0.pop_a = pa;  bus0.pop_b = pb;
    bus1.push = p;  bus1.up_data = d;  bus1.pop_a = pa;  bus1.pop_b = pb;
    @(posedge clk);
    #1;
    model_edge(p, d, pa, pb);
    check_all();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted away from any clock edge, checked before the next edge.
  task automatic do_reset();
    bus0.push = 1'b0;  bus0.pop_a = 1'b0;  bus0.pop_b = 1'b0;
    bus1.push = 1'b0;  bus1.pop_a = 1'b0;  bus1.pop_b = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    mdepth[0] = 4;
    mdepth[1] = 3;
    model_reset();
    rst = 1'b0;
    bus0.push = 1'b0;  bus0.up_data = '0;  bus0.pop_a = 1'b0;  bus0.pop_b = 1'b0;
    bus1.push = 1'b0;  bus1.up_data = '0;  bus1.pop_a = 1'b0;  bus1.pop_b = 1'b0;
    @(negedge clk);
    check_all();
    rst = 1'b1;
    @(negedge clk);

    // Split and latency
    step(1'b1, 12'hA53, 1'b0, 1'b0);
    check("split_a", 32'(bus0.down_data_a), 32'h29);
    check("split_b", 32'(bus0.down_data_b), 32'h13);
    step(1'b0, 12'h000, 1'b1, 1'b1);

    // Independent drain of lane A
    step(1'b1, 12'h041, 1'b0, 1'b0);
    step(1'b1, 12'h082, 1'b0, 1'b0);
    step(1'b1, 12'h0C3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 12'h000, 1'b1, 1'b0);
    check("drain_empty_a", 32'(bus0.empty_a), 32'd1);
    check("drain_count_b", 32'(bus0.count_b), 32'd3);
    check("drain_head_b", 32'(bus0.down_data_b), 32'h01);

    // Mid-stream reset with three entries in both lanes
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 12'(12'h111 * (i + 1)), 1'b0, 1'b0);
    do_reset();
    @(negedge clk);

    // Full, drain B only, dropped push
    for (int i = 0; i < 4; i++) step(1'b1, 12'(12'h0A5 + i * 12'h101), 1'b0, 1'b0);
    check("full_set", 32'(bus0.full), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 12'h000, 1'b0, 1'b1);
    step(1'b1, 12'hFFF, 1'b0, 1'b0);
    check("drop_overflow", 32'(bus0.overflow), 32'd1);
    check("drop_count_a", 32'(bus0.count_a), 32'd4);
    check("drop_count_b", 32'(bus0.count_b), 32'd0);

    // Push with pop on a full lane: push still dropped
    step(1'b1, 12'hEEE, 1'b1, 1'b0);
    check("bnd_count_a", 32'(bus0.count_a), 32'd3);
    check("bnd_overflow", 32'(bus0.overflow), 32'd1);

    // Push with pop at count 2: A unchanged, B grows
    do_reset();
    @(negedge clk);
    step(1'b1, 12'h123, 1'b0, 1'b0);
    step(1'b1, 12'h456, 1'b0, 1'b0);
    step(1'b1, 12'h789, 1'b1, 1'b0);
    check("sim_count_a", 32'(bus0.count_a), 32'd2);
    check("sim_count_b", 32'(bus0.count_b), 32'd3);

    // Steady occupancy 2 across pointer wrap (matters most for DEPTH=3)
    do_reset();
    @(negedge clk);
    step(1'b1, 12'h001, 1'b0, 1'b0);
    step(1'b1, 12'h002, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 12'(12'h0C0 + i * 12'h041), 1'b1, 1'b1);

    // Pop on empty lane is ignored
    do_reset();
    @(negedge clk);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b1);
    check("empty_pop_count_a", 32'(bus1.count_a), 32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 12'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 2) == 0), 12'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
